// File: rtl/mdu_arbiter_pkg.sv
// Shared definitions for the MDU arbiter: op codes, FSM encodings, transaction payload.
// Latency: none (declarations only).
// Backpressure: n/a.
package mdu_arbiter_pkg;

  // M-extension op codes, shared with the MDU and the decoder
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Sequencer state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Watchdog: default abort threshold and counter width (covers the 40..255 range)
  localparam int unsigned TIMEOUT_DEFAULT = 64;
  localparam int unsigned WD_W            = 8;

  // Result returned on a watchdog abort
  localparam logic [31:0] ABORT_RESULT = 32'hFFFF_FFFF;

  // Operation latched at accept and held on the MDU inputs for the whole transaction
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
  } mdu_txn_t;

  // Two-way round-robin pick: a lone requester wins; on a tie ptr selects (0 = req0)
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = ptr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mdu_rr_arb.sv
// Two-way round-robin picker producing a one-hot grant from valid bits and a priority pointer.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own readiness.
module mdu_rr_arb
  import mdu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Pointer names the favoured requester when both are valid
  always_comb begin
    grant = rr_grant(valid, ptr);
  end

endmodule

// File: rtl/mdu_arbiter.sv
// Two-port arbiter/sequencer for the shared MDU with start/done handshake and watchdog abort.
// Latency: accept->start 1 cycle, done->rsp_valid 1 cycle; 3 cycles overhead plus MDU latency.
// Backpressure: one transaction in flight; both req readies low until the response handshakes.
module mdu_arbiter
  import mdu_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,

  output logic        mdu_start,
  output logic [2:0]  mdu_operation,
  output logic [31:0] mdu_x,
  output logic [31:0] mdu_y,
  input  logic        mdu_done,
  input  logic [31:0] mdu_result,
  output logic        mdu_reset
);

  // Last watchdog count value before the abort fires
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]      state_q;
  logic            ptr_q;       // 0 favours req0 on a tie
  logic            gid_q;       // id of the requester being served
  logic [WD_W-1:0] wd_cnt_q;
  logic [31:0]     result_q;
  logic            err_q;
  logic            abort_q;     // one-cycle MDU reset after a watchdog abort
  mdu_txn_t        txn_q;

  logic [1:0]      grant;
  logic            in_idle;
  logic            accept;
  logic            wd_hit;
  logic            rsp_go;
  mdu_txn_t        req_sel;

  mdu_rr_arb u_rr_arb (
    .valid (({req1_valid, req0_valid})),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Handshake decode: only the winner sees ready, and only in IDLE out of reset
  always_comb begin
    in_idle    = reset && (state_q == ST_IDLE);
    req0_ready = in_idle && grant[0];
    req1_ready = in_idle && grant[1];
    accept     = req0_ready || req1_ready;
    wd_hit     = (wd_cnt_q == WD_LAST);
    rsp_go     = (state_q == ST_RESP) && (gid_q ? rsp1_ready : rsp0_ready);
    req_sel    = grant[1] ? mdu_txn_t'({req1_op, req1_x, req1_y})
                          : mdu_txn_t'({req0_op, req0_x, req0_y});
  end

  // Sequencer: IDLE -> ISSUE -> WAIT -> RESP, with watchdog count and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wd_cnt_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          wd_cnt_q <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done in the timeout cycle still counts as a normal completion
          if (mdu_done) begin
            result_q <= mdu_result;
            err_q    <= 1'b0;
            state_q  <= ST_RESP;
          end else if (wd_hit) begin
            result_q <= ABORT_RESULT;
            err_q    <= 1'b1;
            state_q  <= ST_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_go) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Abort pulse lands in the cycle after the timeout, alongside rsp_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= (state_q == ST_WAIT) && !mdu_done && wd_hit;
    end
  end

  // Operand latch: the MDU output mux depends on op, so hold it until the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_q <= '{op: OP_MUL, x: 32'd0, y: 32'd0};
      gid_q <= 1'b0;
    end else if (accept) begin
      txn_q <= req_sel;
      gid_q <= grant[1];
    end
  end

  // Priority pointer moves away from whoever was just served
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else if (rsp_go) begin
      ptr_q <= ~gid_q;
    end
  end

  // Output drive: everything below comes from state or registers
  always_comb begin
    mdu_start     = (state_q == ST_ISSUE);
    mdu_operation = txn_q.op;
    mdu_x         = txn_q.x;
    mdu_y         = txn_q.y;
    rsp0_valid    = (state_q == ST_RESP) && !gid_q;
    rsp1_valid    = (state_q == ST_RESP) && gid_q;
    rsp_data      = result_q;
    rsp_err       = err_q;
    mdu_reset     = !reset || abort_q;
  end

endmodule
